// File: rtl/seq_pkg.sv
// Shared definitions for the datapath sequencer: instruction encodings,
// ALU selects, IR field positions, FSM state codes and the control bundle.
package seq_pkg;

  // Opcode / op encodings of the supported instructions
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // ALU function selects driven onto the datapath
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // IR field bit positions
  localparam int IR_OPC_HI = 15;
  localparam int IR_OPC_LO = 13;
  localparam int IR_OP_HI  = 12;
  localparam int IR_OP_LO  = 11;
  localparam int IR_RN_HI  = 10;
  localparam int IR_RN_LO  = 8;
  localparam int IR_RD_HI  = 7;
  localparam int IR_RD_LO  = 5;
  localparam int IR_SH_HI  = 4;
  localparam int IR_SH_LO  = 3;
  localparam int IR_RM_HI  = 2;
  localparam int IR_RM_LO  = 0;
  localparam int IR_IMM_HI = 7;

  // FSM state codes; ILLEGAL is only reachable with the trap build
  localparam logic [2:0] ST_WAIT    = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_GET_A   = 3'd2;
  localparam logic [2:0] ST_GET_B   = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;
  localparam logic [2:0] ST_WR_REG  = 3'd5;
  localparam logic [2:0] ST_WR_IMM  = 3'd6;
  localparam logic [2:0] ST_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_MOV_IMM = 2'd1,
    CLS_MOV_REG = 2'd2,
    CLS_ALU     = 2'd3
  } instr_cls_e;

  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
  } ctrl_t;

  // Sign-extend the low byte of the instruction to the datapath width
  function automatic logic [15:0] sext_imm8(input logic [15:0] ir);
    return {{8{ir[IR_IMM_HI]}}, ir[IR_IMM_HI:0]};
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction-side handshake plus the datapath control bus of the sequencer.
// The sequencer sits on the slave modport; the instruction source / datapath
// view is the master modport.
interface datapath_sequencer_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        write;
  logic        asel;
  logic        bsel;
  logic        vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport master (
    output s, load, in,
    input  w, readnum, writenum, loada, loadb, loadc, loads, write,
           asel, bsel, vsel, shift, ALUop, datapath_in
  );

  modport slave (
    input  s, load, in,
    output w, readnum, writenum, loada, loadb, loadc, loads, write,
           asel, bsel, vsel, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decoder: classifies the IR and slices out the
// register indices and shift/op fields used by the sequencer.
module seq_decode
  import seq_pkg::*;
(
  input  logic [15:0] ir_i,
  output instr_cls_e  cls_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic [1:0]  op_o,
  output logic        is_cmp_o
);

  logic [2:0] opc_s;

  assign opc_s = ir_i[IR_OPC_HI:IR_OPC_LO];
  assign op_o  = ir_i[IR_OP_HI:IR_OP_LO];
  assign rn_o  = ir_i[IR_RN_HI:IR_RN_LO];
  assign rd_o  = ir_i[IR_RD_HI:IR_RD_LO];
  assign rm_o  = ir_i[IR_RM_HI:IR_RM_LO];
  assign sh_o  = ir_i[IR_SH_HI:IR_SH_LO];

  // Map opcode/op onto an instruction class; anything unlisted is illegal
  always_comb begin
    cls_o    = CLS_ILLEGAL;
    is_cmp_o = 1'b0;
    if (opc_s == OPC_MOV) begin
      if (op_o == OP_MOV_IMM) begin
        cls_o = CLS_MOV_IMM;
      end else if (op_o == OP_MOV_REG) begin
        cls_o = CLS_MOV_REG;
      end else begin
        cls_o = CLS_ILLEGAL;
      end
    end else if (opc_s == OPC_ALU) begin
      cls_o    = CLS_ALU;
      is_cmp_o = (op_o == OP_CMP);
    end else begin
      cls_o = CLS_ILLEGAL;
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction-driven control sequencer for the register-file/ALU datapath.
// Optional build macro SEQ_ILLEGAL_TRAP_EN: unsupported encodings park the
// FSM in ILLEGAL (w=0) until reset instead of returning to WAIT.
// Controls are registered from the next state so they appear exactly in the
// cycle the FSM occupies the corresponding state (Moore timing, glitch-free).
module datapath_sequencer
  import seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  datapath_sequencer_if.slave  bus
);

  logic [2:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        w_q, w_d;
  logic [15:0] dp_in_q;

  instr_cls_e  dec_cls;
  logic [2:0]  dec_rn, dec_rd, dec_rm;
  logic [1:0]  dec_sh, dec_op;
  logic        dec_is_cmp;

  seq_decode u_decode (
    .ir_i     (ir_q),
    .cls_o    (dec_cls),
    .rn_o     (dec_rn),
    .rd_o     (dec_rd),
    .rm_o     (dec_rm),
    .sh_o     (dec_sh),
    .op_o     (dec_op),
    .is_cmp_o (dec_is_cmp)
  );

  // IR only accepts a new word while idle, so it is stable across an instruction
  always_comb begin
    if ((state_q == ST_WAIT) && bus.load) begin
      ir_d = bus.in;
    end else begin
      ir_d = ir_q;
    end
  end

  // Next-state logic of the instruction FSM
  always_comb begin
    state_d = ST_WAIT;
    case (state_q)
      ST_WAIT: begin
        if (bus.s) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DECODE: begin
        case (dec_cls)
          CLS_MOV_IMM: state_d = ST_WR_IMM;
          CLS_MOV_REG: state_d = ST_GET_B;
          CLS_ALU: begin
            if (dec_op == OP_MVN) begin
              state_d = ST_GET_B;
            end else begin
              state_d = ST_GET_A;
            end
          end
`ifdef SEQ_ILLEGAL_TRAP_EN
          default: state_d = ST_ILLEGAL;
`else
          default: state_d = ST_WAIT;
`endif
        endcase
      end
      ST_GET_A: state_d = ST_GET_B;
      ST_GET_B: state_d = ST_EXEC;
      ST_EXEC: begin
        if ((dec_cls == CLS_ALU) && dec_is_cmp) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_WR_REG;
        end
      end
      ST_WR_REG: state_d = ST_WAIT;
      ST_WR_IMM: state_d = ST_WAIT;
`ifdef SEQ_ILLEGAL_TRAP_EN
      ST_ILLEGAL: state_d = ST_ILLEGAL;
`endif
      default: state_d = ST_WAIT;
    endcase
  end

  // Control values for the state being entered; everything unlisted stays 0.
  // IR cannot change once DECODE is left, so decoding ir_q is valid here.
  always_comb begin
    ctrl_d = '0;
    w_d    = (state_d == ST_WAIT);
    case (state_d)
      ST_GET_A: begin
        ctrl_d.readnum = dec_rn;
        ctrl_d.loada   = 1'b1;
      end
      ST_GET_B: begin
        ctrl_d.readnum = dec_rm;
        ctrl_d.loadb   = 1'b1;
      end
      ST_EXEC: begin
        ctrl_d.shift = dec_sh;
        ctrl_d.bsel  = 1'b0;
        if (dec_cls == CLS_MOV_REG) begin
          ctrl_d.asel   = 1'b1;
          ctrl_d.alu_op = ALU_ADD;
          ctrl_d.loadc  = 1'b1;
        end else begin
          ctrl_d.asel   = 1'b0;
          ctrl_d.alu_op = dec_op;
          ctrl_d.loadc  = ~dec_is_cmp;
          ctrl_d.loads  = dec_is_cmp;
        end
      end
      ST_WR_REG: begin
        ctrl_d.writenum = dec_rd;
        ctrl_d.vsel     = 1'b0;
        ctrl_d.write    = 1'b1;
      end
      ST_WR_IMM: begin
        ctrl_d.writenum = dec_rn;
        ctrl_d.vsel     = 1'b1;
        ctrl_d.write    = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, IR and output registers; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= 16'h0000;
      ctrl_q  <= '0;
      w_q     <= 1'b1;
      dp_in_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      w_q     <= w_d;
      dp_in_q <= sext_imm8(ir_d);
    end
  end

  assign bus.w           = w_q;
  assign bus.readnum     = ctrl_q.readnum;
  assign bus.writenum    = ctrl_q.writenum;
  assign bus.loada       = ctrl_q.loada;
  assign bus.loadb       = ctrl_q.loadb;
  assign bus.loadc       = ctrl_q.loadc;
  assign bus.loads       = ctrl_q.loads;
  assign bus.write       = ctrl_q.write;
  assign bus.asel        = ctrl_q.asel;
  assign bus.bsel        = ctrl_q.bsel;
  assign bus.vsel        = ctrl_q.vsel;
  assign bus.shift       = ctrl_q.shift;
  assign bus.ALUop       = ctrl_q.alu_op;
  assign bus.datapath_in = dp_in_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer. A phase-list reference model
// (per instruction class: which datapath step happens on which cycle) gives
// the expected control word after every clock edge.
module tb_datapath_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  datapath_sequencer_if bus();

  datapath_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model phases: what the datapath is being told to do in a given cycle
  localparam int P_IDLE = 0, P_DEC = 1, P_RD_A = 2, P_RD_B = 3,
                 P_ALU = 4, P_WB_REG = 5, P_WB_IMM = 6, P_TRAP = 7;

  function automatic logic [34:0] observed();
    return {bus.w, bus.readnum, bus.writenum, bus.loada, bus.loadb, bus.loadc,
            bus.loads, bus.write, bus.asel, bus.bsel, bus.vsel, bus.shift,
            bus.ALUop, bus.datapath_in};
  endfunction

  function automatic bit is_legal(input logic [15:0] ir);
    return (ir[15:13] == 3'b101) ||
           ((ir[15:13] == 3'b110) && (ir[12:11] == 2'b10 || ir[12:11] == 2'b00));
  endfunction

  // Expected control word for a phase of instruction ir
  function automatic logic [34:0] expect_of(input int ph, input logic [15:0] ir);
    logic       w;
    logic [2:0] rdn, wrn;
    logic       la, lb, lc, ls, wr, as, bs, vs;
    logic [1:0] sh, alu;
    int         imm;
    logic [15:0] dpi;
    w = 1'b0; rdn = 3'd0; wrn = 3'd0; sh = 2'd0; alu = 2'd0;
    la = 1'b0; lb = 1'b0; lc = 1'b0; ls = 1'b0; wr = 1'b0; as = 1'b0; bs = 1'b0; vs = 1'b0;
    imm = int'(ir[7:0]);
    if (imm >= 128) imm = imm - 256;
    dpi = imm[15:0];
    case (ph)
      P_IDLE:  w = 1'b1;
      P_RD_A:  begin rdn = ir[10:8]; la = 1'b1; end
      P_RD_B:  begin rdn = ir[2:0];  lb = 1'b1; end
      P_ALU: begin
        sh = ir[4:3];
        if (ir[15:13] == 3'b110) begin
          as = 1'b1; alu = 2'b00; lc = 1'b1;
        end else begin
          alu = ir[12:11];
          lc  = (ir[12:11] != 2'b01);
          ls  = (ir[12:11] == 2'b01);
        end
      end
      P_WB_REG: begin wrn = ir[7:5];  wr = 1'b1; end
      P_WB_IMM: begin wrn = ir[10:8]; vs = 1'b1; wr = 1'b1; end
      default: ;
    endcase
    return {w, rdn, wrn, la, lb, lc, ls, wr, as, bs, vs, sh, alu, dpi};
  endfunction

  // Cycle-by-cycle phases after the edge that samples s=1
  function automatic void build(input logic [15:0] ir, output int seq[6], output int len);
    for (int i = 0; i < 6; i++) seq[i] = P_IDLE;
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) begin
      seq[0] = P_DEC; seq[1] = P_WB_IMM; len = 3;
    end else if ((ir[15:13] == 3'b110 && ir[12:11] == 2'b00) ||
                 (ir[15:13] == 3'b101 && ir[12:11] == 2'b11)) begin
      seq[0] = P_DEC; seq[1] = P_RD_B; seq[2] = P_ALU; seq[3] = P_WB_REG; len = 5;
    end else if (ir[15:13] == 3'b101 && ir[12:11] == 2'b01) begin
      seq[0] = P_DEC; seq[1] = P_RD_A; seq[2] = P_RD_B; seq[3] = P_ALU; len = 5;
    end else if (ir[15:13] == 3'b101) begin
      seq[0] = P_DEC; seq[1] = P_RD_A; seq[2] = P_RD_B; seq[3] = P_ALU;
      seq[4] = P_WB_REG; len = 6;
    end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
      seq[0] = P_DEC; seq[1] = P_TRAP; len = 2;
`else
      seq[0] = P_DEC; len = 2;
`endif
    end
  endfunction

  // Issue one instruction from WAIT and check every cycle until it finishes
  task automatic run_instr(input logic [15:0] ir, input bit same_edge, input string tag);
    int seq[6];
    int len;
    logic [34:0] exp_v;
    build(ir, seq, len);
    bus.in   = ir;
    bus.load = 1'b1;
    if (!same_edge) begin
      bus.s = 1'b0;
      @(posedge clk); #1;
      bus.load = 1'b0;
      bus.in   = 16'($urandom);
      exp_v = expect_of(P_IDLE, ir);
      cmp_cnt++;
      if (observed() !== exp_v) begin
        err_cnt++;
        $display("FAIL %s load: got %h expected %h", tag, observed(), exp_v);
      end
    end
    bus.s = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      exp_v = expect_of(seq[k], ir);
      cmp_cnt++;
      if (observed() !== exp_v) begin
        err_cnt++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k + 1, observed(), exp_v);
      end
      if (seq[k] == P_IDLE) begin
        bus.s = 1'b0; bus.load = 1'b0;
      end else begin
        bus.s    = 1'($urandom_range(0, 1));
        bus.load = 1'($urandom_range(0, 1));
        bus.in   = 16'($urandom);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.s = 1'b0; bus.load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [34:0] exp_v;
    exp_v = expect_of(P_IDLE, 16'h0000);
    reset = 1'b1; bus.s = 1'b1; bus.load = 1'b1; bus.in = 16'hD0FF;
    #1;
    cmp_cnt++;
    if (observed() !== exp_v) begin
      err_cnt++;
      $display("FAIL reset_state: got %h expected %h", observed(), exp_v);
    end
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++;
    if (observed() !== exp_v) begin
      err_cnt++;
      $display("FAIL reset_held: got %h expected %h", observed(), exp_v);
    end
    bus.s = 1'b0; bus.load = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD007, 1'b1, "mov_imm_d007");
    run_instr(16'hD3FF, 1'b1, "mov_imm_d3ff");
    for (int i = 0; i < 4; i++)
      run_instr({5'b11010, 11'($urandom)}, 1'(i % 2), "mov_imm_rand");
  endtask

  task automatic test_alu();
    run_instr(16'hA148, 1'b1, "add_a148");
    run_instr(16'hA900, 1'b1, "cmp_a900");
    for (int i = 0; i < 8; i++)
      run_instr({3'b101, 2'($urandom), 11'($urandom)}, 1'(i % 2), "alu_rand");
  endtask

  task automatic test_mov_reg();
    for (int i = 0; i < 4; i++)
      run_instr({5'b11000, 11'($urandom)}, 1'(i % 2), "mov_reg_rand");
  endtask

  task automatic test_back_to_back();
    int seq[6];
    int len;
    logic [15:0] ir;
    logic [34:0] exp_v;
    ir = {3'b101, 2'b00, 11'($urandom)};
    build(ir, seq, len);
    bus.in = ir; bus.load = 1'b1; bus.s = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < len; k++) begin
        @(posedge clk); #1;
        bus.load = 1'b0;
        exp_v = expect_of(seq[k], ir);
        cmp_cnt++;
        if (observed() !== exp_v) begin
          err_cnt++;
          $display("FAIL back_to_back run %0d cycle %0d: got %h expected %h",
                   r, k + 1, observed(), exp_v);
        end
      end
    end
    bus.s = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [34:0] exp_v;
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      bus.load = 1'b0; bus.s = 1'b0;
    end
    exp_v = expect_of(P_RD_B, 16'hA148);
    cmp_cnt++;
    if (observed() !== exp_v) begin
      err_cnt++;
      $display("FAIL reset_mid get_b: got %h expected %h", observed(), exp_v);
    end
    #2;
    reset = 1'b1;
    #1;
    exp_v = expect_of(P_IDLE, 16'h0000);
    cmp_cnt++;
    if (observed() !== exp_v) begin
      err_cnt++;
      $display("FAIL reset_mid abort: got %h expected %h", observed(), exp_v);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (bus.write !== 1'b0 || bus.w !== 1'b1) begin
        err_cnt++;
        $display("FAIL reset_mid after %0d: got write=%b w=%b expected write=0 w=1",
                 i, bus.write, bus.w);
      end
    end
  endtask

  task automatic test_illegal();
    logic [34:0] exp_v;
    logic [15:0] ir;
    run_instr(16'hE000, 1'b1, "illegal_e000");
`ifdef SEQ_ILLEGAL_TRAP_EN
    bus.s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_v = expect_of(P_TRAP, 16'hE000);
      cmp_cnt++;
      if (observed() !== exp_v) begin
        err_cnt++;
        $display("FAIL illegal_trap hold %0d: got %h expected %h", i, observed(), exp_v);
      end
    end
    pulse_reset();
    exp_v = expect_of(P_IDLE, 16'h0000);
    cmp_cnt++;
    if (observed() !== exp_v) begin
      err_cnt++;
      $display("FAIL illegal_trap reset: got %h expected %h", observed(), exp_v);
    end
`else
    for (int i = 0; i < 4; i++) begin
      ir = 16'($urandom);
      while (is_legal(ir)) ir = 16'($urandom);
      run_instr(ir, 1'(i % 2), "illegal_rand");
    end
`endif
  endtask

  task automatic test_random();
    logic [15:0] ir;
    for (int i = 0; i < 20; i++) begin
      ir = 16'($urandom);
`ifdef SEQ_ILLEGAL_TRAP_EN
      while (!is_legal(ir)) ir = 16'($urandom);
`endif
      run_instr(ir, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    bus.s = 1'b0; bus.load = 1'b0; bus.in = 16'h0000;
    test_reset();
    @(posedge clk); #1;
    test_mov_imm();
    test_alu();
    test_mov_reg();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
# datapath_sequencer

Instruction-driven control sequencer for the existing register-file/ALU datapath. It replaces manual switch-driven control with an FSM. The block latches a 16-bit instruction and, on a start pulse, drives the datapath's register-read, execute and writeback control inputs over the required cycles. It also supplies the sign-extended immediate on `datapath_in`. It sits between an instruction source (board switches or a later fetch unit) and the datapath, and asserts `w` whenever it is idle and ready for the next instruction.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock; same clock as the datapath.
- `reset` in 1: asynchronous, active-high reset.
- `s` in 1: start; sampled only in state WAIT.
- `load` in 1: instruction-register load enable; honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: idle/ready; 1 only in WAIT.
- `readnum`, `writenum` out 3: register-file read and write indices.
- `loada`, `loadb`, `loadc`, `loads`, `write`, `asel`, `bsel`, `vsel` out 1: datapath controls.
- `shift`, `ALUop` out 2: shifter and ALU selects.
- `datapath_in` out 16: `{{8{ir[7]}}, ir[7:0]}`.

## Operation
- Instruction register (IR) fields:
  - opcode = `ir[15:13]`
  - op = `ir[12:11]`
  - Rn = `ir[10:8]`
  - Rd = `ir[7:5]`
  - sh = `ir[4:3]`
  - Rm = `ir[2:0]`
  - imm8 = `ir[7:0]`
- Supported instructions:
  - MOV Rn,#imm8 (110/10)
  - MOV Rd,Rm{,sh} (110/00)
  - ADD (101/00), CMP (101/01), AND (101/10), MVN (101/11)
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM (plus ILLEGAL when the macro is defined).
- Transitions:
  - WAIT: `s`=1 → DECODE.
  - DECODE: MOV-imm → WR_IMM; MOV-reg/MVN → GET_B; ADD/CMP/AND → GET_A; any other encoding → WAIT.
  - GET_A → GET_B → EXEC.
  - EXEC: CMP → WAIT; all others → WR_REG.
  - WR_REG → WAIT; WR_IMM → WAIT.
- Outputs are Moore, decoded from state plus IR. Every control not listed for a state is 0.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - EXEC: `shift`=sh, `bsel`=0, `loadc`=1 (0 for CMP), `loads`=1 (0 unless CMP).
    - MOV-reg: `asel`=1, `ALUop`=00.
    - ADD/CMP/AND/MVN: `asel`=0, `ALUop`=op.
  - WR_REG: `writenum`=Rd, `vsel`=0, `write`=1.
  - WR_IMM: `writenum`=Rn, `vsel`=1, `write`=1.
- `load`=1 in WAIT captures `in` into the IR at the clock edge.
  - `load` and `s` together in WAIT: the IR captures the new word and DECODE uses it.
  - `load` outside WAIT is ignored; the IR is stable for the whole instruction.

## Timing
- Reset (async, immediate): state=WAIT, IR=0, `w`=1.
  - All controls 0; `readnum`=`writenum`=`shift`=`ALUop`=0; `datapath_in`=0.
- Latency, counted from the edge that samples `s`=1 to the return to WAIT (`w`=1):
  - MOV-imm: 3 cycles.
  - MOV-reg/MVN: 5 cycles.
  - CMP: 5 cycles.
  - ADD/AND: 6 cycles.
- `s` held high: the next instruction starts on the cycle after the return to WAIT, using the current IR.
- `reset` asserted mid-instruction aborts the instruction.
  - No `write` pulse is produced after the reset edge.
  - A register already written is not rolled back.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined:
  - An unsupported encoding in DECODE → ILLEGAL.
  - ILLEGAL: `w`=0, all controls 0, exits only on `reset`.
- Macro undefined: an unsupported encoding returns to WAIT with no control pulses.

## Structure
- Shared package `seq_pkg`:
  - opcode/op constants
  - state enum
  - ALUop constants (ADD=00, SUB=01, AND=10, NOT=11)
  - IR field-slice constants
- One sub-module, `seq_decode`: combinational decoder from IR to instruction class and register indices. It is instantiated once by `datapath_sequencer`.

## Test plan
- Reset mid-ADD (during GET_B) → `w`=1, all controls 0 immediately, and no later `write` pulse.
- `in`=0xD007 with `load`=1 and `s`=1 in WAIT:
  - WR_IMM on cycle 2 with `writenum`=0, `vsel`=1, `write`=1, `datapath_in`=0x0007.
  - `w`=1 on cycle 3.
- `in`=0xD3FF → `datapath_in`=0xFFFF and `writenum`=3 in WR_IMM.
- `in`=0xA148 (ADD R2,R1,R0 LSL1), state sequence GET_A → GET_B → EXEC → WR_REG:
  - GET_A: `readnum`=1, `loada`=1.
  - GET_B: `readnum`=0, `loadb`=1.
  - EXEC: `shift`=01, `ALUop`=00, `loadc`=1.
  - WR_REG: `writenum`=2, `write`=1.
- `in`=0xA900 (CMP R1,R0) → EXEC has `loads`=1, `loadc`=0, `ALUop`=01; no `write` pulse; `w` returns 5 cycles after `s`.
- `in`=0xE000 → no control pulses.
  - Macro undefined: `w`=1 after 2 cycles.
  - Macro defined: `w` stays 0 until `reset`.
